next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/npc_pkg.sv | 26 ++
 rtl/branch_cond.sv | 33 +++
 rtl/next_pc_unit.sv | 155 +++++++++++++++
 tb/tb_next_pc_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared decode constants and pc_sel encoding for the next-PC unit.
package npc_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    typedef enum logic [1:0] {
        SelSeq    = 2'd0,
        SelBranch = 2'd1,
        SelReg    = 2'd2,
        SelJump   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation for conditional branches.
module branch_cond
    import npc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rt_fld,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        taken
);

    logic rs_zero;
    assign rs_zero = (rs_val == 32'd0);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:    taken = (rs_val == rt_val);
            OP_BNE:    taken = (rs_val != rt_val);
            OP_BLEZ:   taken = rs_val[31] | rs_zero;
            OP_BGTZ:   taken = ~rs_val[31] & ~rs_zero;
            OP_REGIMM: begin
                if (rt_fld == RT_BLTZ) begin
                    taken = rs_val[31];
                end else if (rt_fld == RT_BGEZ) begin
                    taken = ~rs_val[31];
                end
            end
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC sequencer: decode-stage branches/jumps, redirects with pending latch.
// Optional performance counters enabled by defining NPC_PERF_CNT_EN.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       instr_d,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic              operands_valid,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_vec,
    output logic [ADDR_W-1:0] pc_f,
    output logic [1:0]        pc_sel,
    output logic              hazard_stall,
    output logic [31:0]       taken_cnt,
    output logic [31:0]       hazard_cnt
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    logic [5:0]        opcode;
    logic [4:0]        rt_fld;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              is_branch, is_jreg, is_jump, cond_taken;
    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_d_plus4, btarget, jtarget, target, pc_nxt;
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_vec_q;
    logic              redirect;

    assign opcode = instr_d[31:26];
    assign rt_fld = instr_d[20:16];
    assign funct  = instr_d[5:0];
    assign imm    = instr_d[15:0];

    branch_cond u_branch_cond (
        .op     (opcode),
        .rt_fld (rt_fld),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (cond_taken)
    );

    always_comb begin
        is_branch = 1'b0;
        is_jreg   = 1'b0;
        is_jump   = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
            OP_REGIMM:  is_branch = (rt_fld == RT_BLTZ) || (rt_fld == RT_BGEZ);
            OP_J, OP_JAL: is_jump = 1'b1;
            OP_SPECIAL: is_jreg   = (funct == FN_JR) || (funct == FN_JALR);
            default: ;
        endcase
    end

    // Jumps carry their target in the instruction, so they never wait on operands.
    assign hazard_stall = (is_branch | is_jreg) & ~operands_valid;

    always_comb begin
        sel = SelSeq;
        if (!hazard_stall) begin
            if (is_jump) begin
                sel = SelJump;
            end else if (is_jreg) begin
                sel = SelReg;
            end else if (is_branch && cond_taken) begin
                sel = SelBranch;
            end
        end
    end
    assign pc_sel = sel;

    assign pc_d_plus4 = pc_d + FOUR;
    assign btarget    = pc_d_plus4 + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};

    always_comb begin
        jtarget       = pc_d_plus4;
        jtarget[27:0] = {instr_d[25:0], 2'b00};
    end

    always_comb begin
        case (sel)
            SelBranch: target = btarget;
            SelReg:    target = rs_val[ADDR_W-1:0];
            SelJump:   target = jtarget;
            default:   target = pc_f + FOUR;
        endcase
    end

    assign redirect = ~stall & (exc_req | pend_valid_q);

    always_comb begin
        if (redirect) begin
            // A fresh request is newer than anything held in the pending latch.
            pc_nxt = exc_req ? exc_vec : pend_vec_q;
        end else if (stall || hazard_stall) begin
            pc_nxt = pc_f;
        end else begin
            pc_nxt = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f         <= RESET_PC[ADDR_W-1:0];
            pend_valid_q <= 1'b0;
            pend_vec_q   <= '0;
        end else begin
            pc_f <= pc_nxt;
            if (stall && exc_req) begin
                pend_valid_q <= 1'b1;
                pend_vec_q   <= exc_vec;
            end else if (!stall) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

`ifdef NPC_PERF_CNT_EN
    logic [31:0] taken_cnt_q, hazard_cnt_q;
    logic        xfer_applied;

    assign xfer_applied = ~redirect & ~stall & (sel != SelSeq);

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            if (xfer_applied && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            if (hazard_stall && (hazard_cnt_q != 32'hFFFF_FFFF)) begin
                hazard_cnt_q <= hazard_cnt_q + 32'd1;
            end
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign hazard_cnt = hazard_cnt_q;
`else
    assign taken_cnt  = '0;
    assign hazard_cnt = '0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed cases plus randomized traffic
// compared every cycle against a behavioural model of the fetch PC rules.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] instr_d = 32'd0;
    logic [31:0] pc_d = 32'h0000_3000;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        operands_valid = 1'b1;
    logic        exc_req = 1'b0;
    logic [31:0] exc_vec = 32'd0;
    logic [31:0] pc_f;
    logic [1:0]  pc_sel;
    logic        hazard_stall;
    logic [31:0] taken_cnt, hazard_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    next_pc_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .operands_valid (operands_valid),
        .exc_req        (exc_req),
        .exc_vec        (exc_vec),
        .pc_f           (pc_f),
        .pc_sel         (pc_sel),
        .hazard_stall   (hazard_stall),
        .taken_cnt      (taken_cnt),
        .hazard_cnt     (hazard_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {hazard, sel} from the instruction-set rules.
    function automatic logic [2:0] model_dec(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b, input logic v);
        logic       needs_ops, tk;
        logic [1:0] s;
        needs_ops = 1'b0;
        tk        = 1'b0;
        s         = 2'd0;
        case (ins[31:26])
            6'd2, 6'd3: s = 2'd3;
            6'd4: begin needs_ops = 1'b1; tk = (a == b); end
            6'd5: begin needs_ops = 1'b1; tk = (a != b); end
            6'd6: begin needs_ops = 1'b1; tk = ($signed(a) <= 0); end
            6'd7: begin needs_ops = 1'b1; tk = ($signed(a) > 0); end
            6'd1: begin
                if (ins[20:16] == 5'd0) begin needs_ops = 1'b1; tk = ($signed(a) < 0); end
                if (ins[20:16] == 5'd1) begin needs_ops = 1'b1; tk = ($signed(a) >= 0); end
            end
            6'd0: begin
                if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) begin needs_ops = 1'b1; s = 2'd2; end
            end
            default: ;
        endcase
        if (needs_ops && s == 2'd0 && tk) s = 2'd1;
        if (needs_ops && !v) return 3'b100;
        return {1'b0, s};
    endfunction

    function automatic logic [31:0] model_tgt(input logic [1:0] s, input logic [31:0] ins,
                                              input logic [31:0] pcd, input logic [31:0] a);
        int off;
        off = $signed(ins[15:0]);
        case (s)
            2'd1:    return pcd + 32'd4 + 32'(off * 4);
            2'd2:    return a;
            default: return ((pcd + 32'd4) & 32'hF000_0000) | {4'd0, ins[25:0], 2'b00};
        endcase
    endfunction

    logic [31:0] m_pc, m_pend_vec, m_taken, m_haz;
    logic        m_pend;

    always @(posedge clk) begin
        logic [2:0] d;
        d = model_dec(instr_d, rs_val, rt_val, operands_valid);
        if (reset) begin
            m_pc    <= 32'h0000_3000;
            m_pend  <= 1'b0;
            m_taken <= 32'd0;
            m_haz   <= 32'd0;
        end else begin
            if (!stall && (exc_req || m_pend)) begin
                m_pc <= exc_req ? exc_vec : m_pend_vec;
            end else if (stall || d[2]) begin
                m_pc <= m_pc;
            end else if (d[1:0] != 2'd0) begin
                m_pc <= model_tgt(d[1:0], instr_d, pc_d, rs_val);
                if (m_taken != 32'hFFFF_FFFF) m_taken <= m_taken + 1;
            end else begin
                m_pc <= m_pc + 32'd4;
            end
            if (d[2] && m_haz != 32'hFFFF_FFFF) m_haz <= m_haz + 1;
            if (stall && exc_req) begin
                m_pend     <= 1'b1;
                m_pend_vec <= exc_vec;
            end else if (!stall) begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] d;
        if (chk_en) begin
            d = model_dec(instr_d, rs_val, rt_val, operands_valid);
            check("pc_f", pc_f, m_pc);
            check("pc_sel", {30'd0, pc_sel}, {30'd0, d[1:0]});
            check("hazard_stall", {31'd0, hazard_stall}, {31'd0, d[2]});
`ifdef NPC_PERF_CNT_EN
            check("taken_cnt", taken_cnt, m_taken);
            check("hazard_cnt", hazard_cnt, m_haz);
`else
            check("taken_cnt", taken_cnt, 32'd0);
            check("hazard_cnt", hazard_cnt, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP  = 32'd0;
    localparam logic [31:0] BEQ3 = {6'd4, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] JR   = {6'd0, 5'd1, 15'd0, 6'd8};
    localparam logic [31:0] JMP  = {6'd2, 26'h000_0C00};

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return {6'h08 + 6'($urandom_range(0, 40)), r[25:0]};
            1:       return {6'd4, r[25:0]};
            2:       return {6'd5, r[25:0]};
            3:       return {6'd6, r[25:0]};
            4:       return {6'd7, r[25:0]};
            5:       return {6'd1, r[25:21], 5'($urandom_range(0, 3)), r[15:0]};
            6:       return {6'd2, r[25:0]};
            7:       return {6'd3, r[25:0]};
            8:       return {6'd0, r[25:6], 6'($urandom_range(8, 9))};
            default: return {6'd0, r[25:6], 6'($urandom_range(0, 63))};
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        tick();
        tick();
        chk_en = 1'b1;

        // Sequential fetch after reset release.
        reset = 1'b0;
        check("reset_pc", pc_f, 32'h0000_3000);
        tick(); check("seq1", pc_f, 32'h0000_3004);
        tick(); check("seq2", pc_f, 32'h0000_3008);
        tick(); check("seq3", pc_f, 32'h0000_300C);

        // beq taken / not taken.
        instr_d = BEQ3; pc_d = 32'h0000_3000; rs_val = 32'd5; rt_val = 32'd5;
        #1 check("beq_sel", {30'd0, pc_sel}, 32'd1);
        tick(); check("beq_tgt", pc_f, 32'h0000_3010);
        rt_val = 32'd6;
        #1 check("beq_nt_sel", {30'd0, pc_sel}, 32'd0);
        tick(); check("beq_nt_pc", pc_f, 32'h0000_3014);

        // Signed compare cases.
        instr_d = {6'd1, 5'd1, 5'd0, 16'h0010}; rs_val = 32'h8000_0000;
        #1 check("bltz_neg", {30'd0, pc_sel}, 32'd1);
        instr_d = {6'd1, 5'd1, 5'd1, 16'h0010}; rs_val = 32'd0;
        #1 check("bgez_zero", {30'd0, pc_sel}, 32'd1);
        instr_d = {6'd6, 5'd1, 5'd0, 16'h0010}; rs_val = 32'd1;
        #1 check("blez_pos", {30'd0, pc_sel}, 32'd0);
        instr_d = {6'd5, 5'd1, 5'd2, 16'h0010}; rs_val = 32'd7; rt_val = 32'd7;
        #1 check("bne_eq", {30'd0, pc_sel}, 32'd0);
        instr_d = NOP;
        tick();

        // jr waiting on operands.
        held = pc_f;
        instr_d = JR; operands_valid = 1'b0;
        #1 check("jr_haz", {31'd0, hazard_stall}, 32'd1);
        tick(); check("jr_hold1", pc_f, held);
        tick(); check("jr_hold2", pc_f, held);
        operands_valid = 1'b1; rs_val = 32'h0000_3400;
        #1 check("jr_sel", {30'd0, pc_sel}, 32'd2);
        tick(); check("jr_tgt", pc_f, 32'h0000_3400);

        // Redirect raised during stall, applied when stall drops over a taken beq.
        instr_d = NOP; stall = 1'b1; exc_req = 1'b1; exc_vec = 32'h0000_4180;
        held = pc_f;
        tick(); exc_req = 1'b0; check("exc_hold1", pc_f, held);
        tick(); check("exc_hold2", pc_f, held);
        stall = 1'b0; instr_d = BEQ3; rs_val = 32'd9; rt_val = 32'd9;
        #1 check("exc_beq_sel", {30'd0, pc_sel}, 32'd1);
        tick(); check("exc_vec", pc_f, 32'h0000_4180);
        instr_d = NOP;
        tick(); check("exc_cleared", pc_f, 32'h0000_4184);

        // Counters: reset, 3 transfers, 2 hazard cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0; instr_d = JMP; pc_d = 32'h0000_3000;
        tick(); tick(); tick();
        check("jmp_tgt", pc_f, 32'h0000_3000);
        instr_d = JR; operands_valid = 1'b0;
        tick(); tick();
`ifdef NPC_PERF_CNT_EN
        check("cnt_taken3", taken_cnt, 32'd3);
        check("cnt_haz2", hazard_cnt, 32'd2);
`else
        check("cnt_taken_off", taken_cnt, 32'd0);
        check("cnt_haz_off", hazard_cnt, 32'd0);
`endif
        stall = 1'b1; reset = 1'b1; operands_valid = 1'b1; instr_d = NOP;
        tick();
        check("rst_mid_pc", pc_f, 32'h0000_3000);
        check("rst_mid_taken", taken_cnt, 32'd0);
        check("rst_mid_haz", hazard_cnt, 32'd0);
        stall = 1'b0; reset = 1'b0;

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            instr_d        = pick_instr();
            pc_d           = $urandom & 32'hFFFF_FFFC;
            rs_val         = pick_val();
            rt_val         = ($urandom_range(0, 1) == 0) ? rs_val : pick_val();
            operands_valid = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 4) == 0);
            exc_req        = ($urandom_range(0, 19) == 0);
            exc_vec        = $urandom & 32'hFFFF_FFFC;
            reset          = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
